// File: rtl/uart_wrapper.sv
// uart_wrapper: 8N1 UART receiver, transmitter and 3-byte packet assembler.
// Ports: clk, rst_n, RX/TX pins, cmd/data/cmd_rdy/clr_cmd_rdy packet side,
//        resp/send_resp/resp_sent response side.
module uart_wrapper #(
   parameter int BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);

   typedef enum logic [1:0] {
      WAIT_CMD = 2'd0,
      WAIT_HI  = 2'd1,
      WAIT_LO  = 2'd2
   } pkt_e;

   // ---------------- RX synchronizer ----------------
   logic rx_s1_q, rx_s2_q, rx_s3_q;
   logic rx_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_s3_q <= 1'b1;
      end else begin
         rx_s1_q <= RX;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
      end
   end

   assign rx_fall = rx_s3_q & ~rx_s2_q;

   // ---------------- RX engine ----------------
   logic          rx_busy_q, rx_busy_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [3:0]    rx_bit_q, rx_bit_d;
   logic [8:0]    rx_shift_q, rx_shift_d;
   logic          rx_rdy;
   logic [7:0]    rx_byte;

   // At the stop sample the data bits sit in [8:1]; the stop bit is
   // still on the pin, so the byte is released in that same cycle.
   assign rx_byte = rx_shift_q[8:1];

   always_comb begin
      rx_busy_d  = rx_busy_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_rdy     = 1'b0;
      if (!rx_busy_q) begin
         if (rx_fall) begin
            rx_busy_d = 1'b1;
            rx_cnt_d  = HALF;
            rx_bit_d  = 4'd0;
         end
      end else if (rx_cnt_q != '0) begin
         rx_cnt_d = rx_cnt_q - 1'b1;
      end else begin
         rx_cnt_d = FULL;
         rx_bit_d = rx_bit_q + 4'd1;
         if (rx_bit_q == 4'd0) begin
            // start bit high again: glitch
            if (rx_s2_q) rx_busy_d = 1'b0;
         end else begin
            rx_shift_d = {rx_s2_q, rx_shift_q[8:1]};
            if (rx_bit_q == 4'd9) begin
               rx_busy_d = 1'b0;
               rx_rdy    = rx_s2_q;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_busy_q  <= 1'b0;
         rx_cnt_q   <= '0;
         rx_bit_q   <= 4'd0;
         rx_shift_q <= '0;
      end else begin
         rx_busy_q  <= rx_busy_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // ---------------- Packet FSM ----------------
   pkt_e        pkt_q, pkt_d;
   logic [7:0]  cmd_hold_q, cmd_hold_d;
   logic [7:0]  hi_hold_q, hi_hold_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [15:0] data_q, data_d;
   logic        cmd_rdy_q, cmd_rdy_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pkt_q <= WAIT_CMD;
      else        pkt_q <= pkt_d;
   end

   always_comb begin
      pkt_d = pkt_q;
      if (rx_rdy) begin
         unique case (pkt_q)
            WAIT_CMD: pkt_d = WAIT_HI;
            WAIT_HI:  pkt_d = WAIT_LO;
            WAIT_LO:  pkt_d = WAIT_CMD;
            default:  pkt_d = WAIT_CMD;
         endcase
      end
   end

   always_comb begin
      cmd_hold_d = cmd_hold_q;
      hi_hold_d  = hi_hold_q;
      cmd_d      = cmd_q;
      data_d     = data_q;
      cmd_rdy_d  = cmd_rdy_q;
      if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
      if (rx_rdy) begin
         unique case (pkt_q)
            WAIT_CMD: begin
               cmd_hold_d = rx_byte;
               cmd_rdy_d  = 1'b0;
            end
            WAIT_HI: hi_hold_d = rx_byte;
            WAIT_LO: begin
               // set overrides a same-cycle clr_cmd_rdy
               cmd_d     = cmd_hold_q;
               data_d    = {hi_hold_q, rx_byte};
               cmd_rdy_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_hold_q <= 8'h00;
         hi_hold_q  <= 8'h00;
         cmd_q      <= 8'h00;
         data_q     <= 16'h0000;
         cmd_rdy_q  <= 1'b0;
      end else begin
         cmd_hold_q <= cmd_hold_d;
         hi_hold_q  <= hi_hold_d;
         cmd_q      <= cmd_d;
         data_q     <= data_d;
         cmd_rdy_q  <= cmd_rdy_d;
      end
   end

   assign cmd     = cmd_q;
   assign data    = data_q;
   assign cmd_rdy = cmd_rdy_q;

   // ---------------- TX engine ----------------
   logic          tx_busy_q, tx_busy_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]    tx_bit_q, tx_bit_d;
   logic [9:0]    tx_shift_q, tx_shift_d;
   logic          resp_sent_q, resp_sent_d;

   always_comb begin
      tx_busy_d   = tx_busy_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      resp_sent_d = resp_sent_q;
      if (!tx_busy_q) begin
         if (send_resp) begin
            tx_busy_d   = 1'b1;
            tx_shift_d  = {1'b1, resp, 1'b0};
            tx_cnt_d    = FULL;
            tx_bit_d    = 4'd0;
            resp_sent_d = 1'b0;
         end
      end else if (tx_cnt_q != '0) begin
         tx_cnt_d = tx_cnt_q - 1'b1;
      end else if (tx_bit_q == 4'd9) begin
         tx_busy_d   = 1'b0;
         resp_sent_d = 1'b1;
      end else begin
         // fill with ones so the line idles high after the frame
         tx_shift_d = {1'b1, tx_shift_q[9:1]};
         tx_bit_d   = tx_bit_q + 4'd1;
         tx_cnt_d   = FULL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_busy_q   <= 1'b0;
         tx_cnt_q    <= '0;
         tx_bit_q    <= 4'd0;
         tx_shift_q  <= '1;
         resp_sent_q <= 1'b0;
      end else begin
         tx_busy_q   <= tx_busy_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         resp_sent_q <= resp_sent_d;
      end
   end

   assign TX        = tx_shift_q[0];
   assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_wrapper.sv
// tb_uart_wrapper: directed bench for uart_wrapper at BAUD_DIV=16.
// Drives RX frames and response requests, checks packet and TX outputs.
module tb_uart_wrapper;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RX;
   logic        TX;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  resp;
   logic        send_resp;
   logic        resp_sent;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_wrapper #(.BAUD_DIV(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .TX         (TX),
      .cmd        (cmd),
      .data       (data),
      .cmd_rdy    (cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy),
      .resp       (resp),
      .send_resp  (send_resp),
      .resp_sent  (resp_sent)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One 8N1 frame, 16 cycles per bit. With timed set, cmd_rdy must
   // still be low right after the stop-bit sample cycle begins and be
   // high with ec/ed one cycle later.
   task automatic send_byte(input logic [7:0] b, input bit stop_ok,
                            input bit timed, input logic [7:0] ec,
                            input logic [15:0] ed, input string tag);
      logic [9:0] f;
      f = {stop_ok, b, 1'b0};
      for (int k = 0; k < 9; k++) begin
         RX = f[k];
         repeat (16) tick();
      end
      RX = f[9];
      if (timed) begin
         repeat (11) tick();
         chk({tag, "_rdy_early"}, 32'(cmd_rdy), 32'd0);
         tick();
         chk({tag, "_rdy"}, 32'(cmd_rdy), 32'd1);
         chk({tag, "_cmd"}, 32'(cmd), 32'(ec));
         chk({tag, "_data"}, 32'(data), 32'(ed));
         repeat (4) tick();
      end else begin
         repeat (16) tick();
      end
      if (!stop_ok) begin
         RX = 1'b1;
         repeat (16) tick();
      end
   endtask

   initial begin
      logic [9:0] fr;
      RX          = 1'b1;
      rst_n       = 1'b0;
      clr_cmd_rdy = 1'b0;
      resp        = 8'h00;
      send_resp   = 1'b0;
      #1;
      repeat (3) tick();
      chk("rst_tx", 32'(TX), 32'd1);
      chk("rst_cmd", 32'(cmd), 32'h00);
      chk("rst_data", 32'(data), 32'h0000);
      chk("rst_rdy", 32'(cmd_rdy), 32'd0);
      chk("rst_sent", 32'(resp_sent), 32'd0);
      rst_n = 1'b1;
      repeat (5) tick();
      chk("idle_tx", 32'(TX), 32'd1);

      // basic packet
      send_byte(8'h06, 1'b1, 1'b0, 8'h00, 16'h0000, "p1a");
      send_byte(8'hBE, 1'b1, 1'b0, 8'h00, 16'h0000, "p1b");
      chk("p1_partial", 32'(cmd_rdy), 32'd0);
      send_byte(8'hEF, 1'b1, 1'b1, 8'h06, 16'hBEEF, "p1");
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      chk("clr_rdy", 32'(cmd_rdy), 32'd0);
      chk("clr_cmd", 32'(cmd), 32'h06);

      // short packet merges with next
      send_byte(8'h02, 1'b1, 1'b0, 8'h00, 16'h0000, "p2a");
      send_byte(8'h12, 1'b1, 1'b0, 8'h00, 16'h0000, "p2b");
      chk("p2_nordy", 32'(cmd_rdy), 32'd0);
      chk("p2_cmd_hold", 32'(cmd), 32'h06);
      chk("p2_data_hold", 32'(data), 32'hBEEF);
      send_byte(8'h05, 1'b1, 1'b1, 8'h02, 16'h1205, "p2");
      send_byte(8'h00, 1'b1, 1'b0, 8'h00, 16'h0000, "p3a");
      chk("p3_newpkt_rdy", 32'(cmd_rdy), 32'd0);
      chk("p3_cmd_hold", 32'(cmd), 32'h02);
      chk("p3_data_hold", 32'(data), 32'h1205);
      send_byte(8'h80, 1'b1, 1'b0, 8'h00, 16'h0000, "p3b");
      send_byte(8'h01, 1'b1, 1'b1, 8'h00, 16'h8001, "p3");

      // new packet clears cmd_rdy, outputs held
      send_byte(8'h06, 1'b1, 1'b0, 8'h00, 16'h0000, "p4a");
      send_byte(8'hBE, 1'b1, 1'b0, 8'h00, 16'h0000, "p4b");
      send_byte(8'hEF, 1'b1, 1'b1, 8'h06, 16'hBEEF, "p4");
      send_byte(8'h07, 1'b1, 1'b0, 8'h00, 16'h0000, "p5a");
      chk("p5_rdy_clr", 32'(cmd_rdy), 32'd0);
      chk("p5_cmd_hold", 32'(cmd), 32'h06);
      chk("p5_data_hold", 32'(data), 32'hBEEF);
      send_byte(8'h12, 1'b1, 1'b0, 8'h00, 16'h0000, "p5b");
      chk("p5b_cmd_hold", 32'(cmd), 32'h06);
      send_byte(8'h34, 1'b1, 1'b1, 8'h07, 16'h1234, "p5");

      // glitch and framing error are both dropped
      RX = 1'b0;
      repeat (4) tick();
      RX = 1'b1;
      repeat (20) tick();
      chk("glitch_rdy", 32'(cmd_rdy), 32'd1);
      send_byte(8'h99, 1'b0, 1'b0, 8'h00, 16'h0000, "ferr");
      chk("ferr_rdy", 32'(cmd_rdy), 32'd1);
      chk("ferr_cmd", 32'(cmd), 32'h07);
      send_byte(8'hA1, 1'b1, 1'b0, 8'h00, 16'h0000, "p6a");
      chk("p6a_rdy", 32'(cmd_rdy), 32'd0);
      send_byte(8'hB2, 1'b1, 1'b0, 8'h00, 16'h0000, "p6b");
      chk("p6b_rdy", 32'(cmd_rdy), 32'd0);
      send_byte(8'hC3, 1'b1, 1'b1, 8'hA1, 16'hB2C3, "p6");

      // response frame 0xA5, second request mid-frame ignored
      fr        = {1'b1, 8'hA5, 1'b0};
      resp      = 8'hA5;
      send_resp = 1'b1;
      for (int c = 1; c <= 161; c++) begin
         tick();
         send_resp = (c == 50);
         if (c == 50) resp = 8'h3C;
         if (c <= 160) chk($sformatf("tx_c%0d", c), 32'(TX),
                           32'(fr[(c-1)/16]));
         if (c == 1 || c == 160)
            chk($sformatf("sent_lo_c%0d", c), 32'(resp_sent), 32'd0);
      end
      chk("sent_hi", 32'(resp_sent), 32'd1);
      chk("tx_idle", 32'(TX), 32'd1);
      repeat (20) tick();
      chk("sent_hold", 32'(resp_sent), 32'd1);
      chk("tx_idle2", 32'(TX), 32'd1);

      // reset mid-packet and mid-frame
      send_byte(8'h11, 1'b1, 1'b0, 8'h00, 16'h0000, "r1a");
      resp      = 8'h5A;
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      chk("r_tx_start", 32'(TX), 32'd0);
      chk("r_sent_clr", 32'(resp_sent), 32'd0);
      RX = 1'b0;
      repeat (20) tick();
      chk("r_tx_bit1", 32'(TX), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("r_tx", 32'(TX), 32'd1);
      chk("r_rdy", 32'(cmd_rdy), 32'd0);
      chk("r_cmd", 32'(cmd), 32'h00);
      chk("r_data", 32'(data), 32'h0000);
      chk("r_sent", 32'(resp_sent), 32'd0);
      RX = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      send_byte(8'h33, 1'b1, 1'b0, 8'h00, 16'h0000, "r2a");
      send_byte(8'h44, 1'b1, 1'b0, 8'h00, 16'h0000, "r2b");
      chk("r2_partial", 32'(cmd_rdy), 32'd0);
      send_byte(8'h55, 1'b1, 1'b1, 8'h33, 16'h4455, "r2");
      chk("r2_tx_idle", 32'(TX), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_wrapper.md
# uart_wrapper

Serial front end of the QuadCopter that sits between the RX/TX pins and cmd_cfg. It deserializes 8N1 UART bytes from the remote host and assembles each 3-byte packet (command, data high, data low) into a parallel cmd/data pair with a ready flag. It also serializes the single-byte response that cmd_cfg returns (0xA5 positive acknowledge or any other value). The block holds the UART receiver, the UART transmitter and the packet-assembly FSM.

## Interface
- BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud); legal range ≥ 8.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RX  in  1  serial input from host, idle high, asynchronous to clk.
- TX  out  1  serial output to host, idle high.
- cmd  out  8  first byte of the last complete packet.
- data  out  16  {second byte, third byte} of the last complete packet.
- cmd_rdy  out  1  complete packet available.
- clr_cmd_rdy  in  1  consumer knocks down cmd_rdy.
- resp  in  8  response byte to transmit.
- send_resp  in  1  single-cycle request to transmit resp.
- resp_sent  out  1  response transmission finished.

## Operation
- RX path:
  - RX passes through a 2-flop synchronizer, with an additional flop used to detect edges.
  - In the idle state, a falling edge starts a bit counter preloaded to BAUD_DIV/2.
  - Sampling occurs at the middle of the start bit, then every BAUD_DIV cycles.
  - A 9-bit shift register captures 8 data bits, LSB first, followed by the stop bit.
  - A start bit sampled high is treated as a glitch: the receiver returns to idle and produces no byte.
  - A stop bit sampled low is a framing error: the byte is discarded and packet FSM state is unchanged.
  - A good byte pulses internal rx_rdy for 1 cycle at the stop-bit sample.
- Packet FSM states and transitions:
  - WAIT_CMD: on rx_rdy, capture the byte into a cmd holding register, then go to WAIT_HI.
  - WAIT_HI: on rx_rdy, capture the data high byte, then go to WAIT_LO.
  - WAIT_LO: on rx_rdy, capture the data low byte, load cmd and data from the holding registers, set cmd_rdy, then go to WAIT_CMD.
- cmd and data update only when the third byte completes. Partial packets never disturb outputs the consumer is reading.
- cmd_rdy clear conditions:
  - It clears on clr_cmd_rdy.
  - It also clears on rx_rdy in WAIT_CMD, meaning a new packet has started.
  - If a set and a clear coincide in the same cycle, the set wins.
- No packet timeout. The FSM waits indefinitely between bytes.
- TX path:
  - send_resp is accepted only when the transmitter is idle; a send_resp while busy is ignored.
  - On accept, {1'b1, resp, 1'b0} is loaded into a 10-bit shift register, and resp_sent clears.
  - Each bit is held for BAUD_DIV cycles, LSB first after the start bit.
  - After the 10th bit period, the transmitter returns to idle and resp_sent sets.
  - resp_sent stays set until the next accepted send_resp.
- RX and TX run fully independently (full duplex).

## Timing
- Reset values: TX=1, cmd=0x00, data=0x0000, cmd_rdy=0, resp_sent=0, FSM=WAIT_CMD, both UART engines idle.
- An RX falling edge on the pin is seen 3 cycles later (synchronizer plus edge flop).
- Byte sample occurs at about 9.5·BAUD_DIV cycles after the detected edge.
- cmd_rdy, cmd and data are valid 1 cycle after rx_rdy for the third byte.
- TX drops to 0 one cycle after send_resp is accepted.
- resp_sent rises 10·BAUD_DIV + 1 cycles after send_resp.
- Reset mid-packet or mid-byte:
  - All state returns to its reset values immediately.
  - A partial packet is lost.
  - TX goes high immediately, truncating the frame.

## Test plan
- BAUD_DIV=16. Send bytes 0x06, 0xBE, 0xEF. Required: cmd_rdy rises 1 cycle after the 3rd stop-bit sample, with cmd=0x06 and data=0xBEEF. Pulse clr_cmd_rdy and cmd_rdy=0 on the next cycle.
- Send 0x02, 0x12 only, then 0x05, 0x00, 0x80. Required: no cmd_rdy after the first two bytes, because the FSM treats 0x05 as the third byte. Result is cmd=0x02, data=0x1205. The following bytes start a new packet.
- With cmd_rdy set holding cmd=0x06, send first byte 0x07. Required: cmd_rdy clears at that byte's rx_rdy, and cmd/data keep 0x06/0xBEEF until the packet completes.
- Send a byte with the stop bit driven low. Required: the byte is discarded, no FSM advance, and the next valid 3 bytes produce a correct packet.
- send_resp with resp=0xA5. Required: TX shows start bit 0, then 1,0,1,0,0,1,0,1, then stop bit 1, each bit 16 cycles wide. resp_sent rises at cycle 161. A second send_resp pulsed mid-frame is ignored.
- Assert rst_n low during the 2nd byte of a packet and during a TX frame. Required: TX=1 and cmd_rdy=0 immediately, and a fresh full packet afterwards decodes correctly.
